minibus_rr_arbiter: RTL and testbench
=====================================

MINIBUS_RR_ARBITER -- requirements
Module: minibus_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of master ports (2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 256, busy cycles before forced error response (0 disables timeout).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port m_req  input  NUM_MASTERS x minibus_req_pack  per-master requests.
REQ-006 SHALL have port m_res  output  NUM_MASTERS x minibus_res_pack  per-master responses.
REQ-007 SHALL have port s_req  output  minibus_req_pack  request to decoder.
REQ-008 SHALL have port s_res  input  minibus_res_pack  response from decoder.
REQ-009 SHALL have port grant_id  output  $clog2(NUM_MASTERS)  index of the granted master; valid while busy.
REQ-010 SHALL have port busy  output  1  transaction in flight.

Function
REQ-011 SHALL treat a master as requesting when its ren or wen is 1.
REQ-012 SHALL implement states IDLE and BUSY (minibus_arb_state_e).
REQ-013 IDLE: when any master requests, SHALL pick the first requester at or after rr_ptr (wrapping modulo NUM_MASTERS), register grant_id, and enter BUSY on the next edge.
REQ-014 IDLE: s_req SHALL be all-zero and every m_res SHALL be all-zero.
REQ-015 BUSY: s_req SHALL equal m_req[grant_id] combinationally.
REQ-016 BUSY: m_res[grant_id] SHALL equal s_res, and all other m_res SHALL be all-zero.
REQ-017 BUSY with s_res.ready=1: the cycle SHALL complete the transfer, set rr_ptr to grant_id+1 (wrapping to 0), and return to IDLE.
REQ-018 Minimum cost SHALL be one IDLE arbitration cycle per transfer; back-to-back transfers alternate IDLE/BUSY.
REQ-019 BUSY: a counter SHALL increment each cycle without ready; on reaching TIMEOUT_CYCLES-1, m_res[grant_id] SHALL show ready=1, error=1, rdata=0 for one cycle, s_req SHALL be zeroed that cycle, and the arbiter SHALL return to IDLE with rr_ptr advanced.
REQ-020 Timeout and s_res.ready in the same cycle: ready SHALL win, the response SHALL be forwarded unchanged, and error SHALL not be forced.
REQ-021 Granted master dropping ren and wen while BUSY (protocol violation): the arbiter SHALL return to IDLE next edge without a response and advance rr_ptr.
REQ-022 Masters SHALL hold req stable until they see ready; the arbiter SHALL not buffer requests.
REQ-023 Counter width SHALL be $clog2(TIMEOUT_CYCLES)+1, saturating; the counter SHALL clear on entry to BUSY.
REQ-024 Single requester: the arbiter SHALL re-grant the same master on its next request regardless of rr_ptr.

Reset
REQ-025 nrst low SHALL immediately force state=IDLE, rr_ptr=0, grant_id=0, counter=0, busy=0, s_req=0, and all m_res=0.
REQ-026 Reset mid-BUSY SHALL abandon the transfer with no response issued; after reset the arbiter SHALL resume arbitration from rr_ptr=0.

Structure
REQ-027 minibus_pkg SHALL hold minibus_req_pack {ren, wen, addr[31:0], wdata[31:0], wstrb[3:0]}, minibus_res_pack {ready, error, rdata[31:0]}, and minibus_arb_state_e.
REQ-028 Rotating-priority selection SHALL live in the combinational sub-module minibus_rr_picker (inputs: request vector, rr_ptr; outputs: grant index, any).
REQ-029 The existing minibus_master_if decoder modport SHALL connect to s_req/s_res unchanged.

Verification
REQ-030 Masters 0 and 2 request reads at the same cycle after reset -> master 0 is granted first; after its ready, master 2 is granted; grant_id sequence is 0,2.
REQ-031 All 4 masters request writes continuously and the decoder returns ready 1 cycle into BUSY -> grants rotate 0,1,2,3,0, and each master completes once per 8 cycles.
REQ-032 Master 1 reads addr 0x100, decoder returns rdata=0xDEADBEEF with ready -> m_res[1].rdata=0xDEADBEEF, and the other m_res stay zero.
REQ-033 TIMEOUT_CYCLES=8 and the decoder never readies -> m_res[g] shows ready=1, error=1 on the 8th BUSY cycle, then state is IDLE.
REQ-034 nrst pulsed low during BUSY -> busy=0 and s_req=0 asynchronously; the next grant goes to master 0 if it is requesting.
REQ-035 s_res.ready coincides with the timeout cycle -> error=0 and the real rdata is forwarded.

Source files
------------

// File: rtl/minibus_pkg.sv
// minibus_pkg: shared minibus request/response types and arbiter state
package minibus_pkg;
  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } minibus_req_pack;
  typedef struct packed {
    logic        ready;
    logic        error;
    logic [31:0] rdata;
  } minibus_res_pack;
  typedef enum logic {IDLE, BUSY} minibus_arb_state_e;
  function automatic logic req_active(input minibus_req_pack r);
    return r.ren | r.wen;
  endfunction
endpackage

// File: rtl/minibus_rr_picker.sv
// minibus_rr_picker: first requester at or after ptr, wrapping modulo N
module minibus_rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          any
);
  logic [IW-1:0] idx;
  // Walk offsets from farthest to nearest so the nearest requester wins last
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = IW'((int'(ptr) + i) % N);
      if (req[idx]) grant = idx;
    end
  end
  assign any = |req;
endmodule

// File: rtl/minibus_rr_arbiter.sv
// minibus_rr_arbiter: round-robin N-master to single-decoder minibus arbiter
module minibus_rr_arbiter
  import minibus_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int IW = $clog2(NUM_MASTERS),
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1
) (
  input  logic                               clk,
  input  logic                               nrst,
  input  minibus_req_pack [NUM_MASTERS-1:0] m_req,
  output minibus_res_pack [NUM_MASTERS-1:0] m_res,
  output minibus_req_pack                    s_req,
  input  minibus_res_pack                    s_res,
  output logic [IW-1:0]                      grant_id,
  output logic                               busy
);
  minibus_arb_state_e     state;
  logic [IW-1:0]          rr_ptr, pick, next_ptr;
  logic [CW-1:0]          cnt;
  logic [NUM_MASTERS-1:0] reqs;
  logic                   any, active, timeout;
  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_req
    assign reqs[g] = req_active(m_req[g]);
  end
  minibus_rr_picker #(.N(NUM_MASTERS)) u_picker (
    .req  (reqs),
    .ptr  (rr_ptr),
    .grant(pick),
    .any  (any)
  );
  assign busy     = state == BUSY;
  assign active   = reqs[grant_id];
  assign next_ptr = int'(grant_id) == NUM_MASTERS - 1 ? '0 : grant_id + IW'(1);
  assign timeout  = TIMEOUT_CYCLES != 0 && int'(cnt) == TIMEOUT_CYCLES - 1 && !s_res.ready && active;
  // Connect the granted master to the decoder; a timeout substitutes an error reply
  always_comb begin
    s_req = busy && !timeout ? m_req[grant_id] : '0;
    m_res = '0;
    if (busy) m_res[grant_id] = timeout ? minibus_res_pack'{ready: 1'b1, error: 1'b1, rdata: 32'h0} : s_res;
  end
  // Arbitrate in IDLE; leave BUSY on ready, timeout or an abandoned request
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      cnt      <= '0;
    end else if (!busy) begin
      if (any) begin
        state    <= BUSY;
        grant_id <= pick;
        cnt      <= '0;
      end
    end else if (s_res.ready || !active || timeout) begin
      state  <= IDLE;
      rr_ptr <= next_ptr;
    end else if (cnt != '1) begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_minibus_rr_arbiter.sv
// tb_minibus_rr_arbiter: scenario tests plus randomized run against a rule-level model
module tb_minibus_rr_arbiter;
  import minibus_pkg::*;
  localparam int N = 4, TO = 8;
  logic clk = 1'b0, nrst = 1'b0;
  minibus_req_pack [N-1:0] m_req;
  minibus_res_pack [N-1:0] m_res;
  minibus_req_pack s_req;
  minibus_res_pack s_res;
  logic [1:0] grant_id;
  logic busy;
  int errors = 0, checks = 0;
  int md_busy, md_grant, md_ptr, md_wait;
  logic e_to;
  minibus_req_pack e_sreq;
  minibus_res_pack [N-1:0] e_mres;

  minibus_rr_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .nrst(nrst), .m_req(m_req), .m_res(m_res),
    .s_req(s_req), .s_res(s_res), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Expected bus view derived from the model's transfer state and current inputs
  always_comb begin
    e_to   = md_busy != 0 && !s_res.ready && (m_req[md_grant].ren || m_req[md_grant].wen) && md_wait == TO - 1;
    e_sreq = '0;
    e_mres = '0;
    if (md_busy != 0) begin
      if (!e_to) e_sreq = m_req[md_grant];
      e_mres[md_grant] = e_to ? minibus_res_pack'{ready: 1'b1, error: 1'b1, rdata: 32'h0} : s_res;
    end
  end

  function automatic minibus_req_pack mk(logic ren, logic wen, logic [31:0] addr, logic [31:0] wdata);
    return '{ren: ren, wen: wen, addr: addr, wdata: wdata, wstrb: 4'hF};
  endfunction

  function automatic logic [N-1:0] reqv();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_req[i].ren | m_req[i].wen;
    return r;
  endfunction

  task automatic model_reset();
    md_busy = 0; md_grant = 0; md_ptr = 0; md_wait = 0;
  endtask

  // Advance the model by one clock using the arbitration rules, then move to the next negedge
  task automatic tick();
    logic [N-1:0] r;
    int f;
    r = reqv();
    if (md_busy == 0) begin
      f = -1;
      for (int k = 0; k < N; k++) if (f < 0 && r[(md_ptr + k) % N]) f = (md_ptr + k) % N;
      if (f >= 0) begin md_busy = 1; md_grant = f; md_wait = 0; end
    end else if (s_res.ready || !r[md_grant] || e_to) begin
      md_busy = 0;
      md_ptr = (md_grant + 1) % N;
    end else md_wait++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    nrst = 1'b0; m_req = '0; s_res = '0; model_reset();
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; m_req = '0; m_req[1] = mk(1, 0, 32'h4, 0);
    s_res = '{ready: 1'b1, error: 1'b0, rdata: 32'hFFFF}; model_reset();
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant got=%0d exp=0", grant_id); end
    checks++; if (s_req !== '0) begin errors++; $display("FAIL reset_sreq got=%h exp=0", s_req); end
    checks++; if (m_res !== '0) begin errors++; $display("FAIL reset_mres got=%h exp=0", m_res); end
    @(negedge clk);
    nrst = 1'b1; m_req = '0; s_res = '0;
  endtask

  task automatic test_pair();
    int seq[$];
    logic [N-1:0] done;
    do_reset();
    m_req[0] = mk(1, 0, 32'h10, 0);
    m_req[2] = mk(1, 0, 32'h20, 0);
    for (int t = 0; t < 20 && seq.size() < 2; t++) begin
      s_res = md_busy != 0 ? minibus_res_pack'{ready: 1'b1, error: 1'b0, rdata: 32'h1000 + t} : '0;
      #1;
      if (busy) seq.push_back(int'(grant_id));
      checks++; if (m_res !== e_mres) begin errors++; $display("FAIL pair_mres got=%h exp=%h", m_res, e_mres); end
      for (int i = 0; i < N; i++) done[i] = e_mres[i].ready;
      tick();
      for (int i = 0; i < N; i++) if (done[i]) m_req[i] = '0;
    end
    while (seq.size() < 2) seq.push_back(-1);
    checks++;
    if (seq[0] != 0 || seq[1] != 2) begin errors++; $display("FAIL pair_seq got=%0d,%0d exp=0,2", seq[0], seq[1]); end
    m_req = '0; s_res = '0;
  endtask

  task automatic test_rotate();
    int gseq[$];
    int last[N];
    do_reset();
    for (int i = 0; i < N; i++) begin m_req[i] = mk(0, 1, 32'(i * 16), 32'(i)); last[i] = -1; end
    for (int t = 0; t < 40; t++) begin
      s_res = md_busy != 0 ? minibus_res_pack'{ready: 1'b1, error: 1'b0, rdata: 32'h0} : '0;
      #1;
      checks++;
      if (busy !== (md_busy != 0) || s_req !== e_sreq) begin
        errors++; $display("FAIL rotate_bus t=%0d busy=%0b sreq=%h exp busy=%0d sreq=%h", t, busy, s_req, md_busy, e_sreq);
      end
      if (busy) gseq.push_back(int'(grant_id));
      for (int i = 0; i < N; i++) if (m_res[i].ready) begin
        if (last[i] >= 0) begin
          checks++; if (t - last[i] != 8) begin errors++; $display("FAIL rotate_gap m%0d got=%0d exp=8", i, t - last[i]); end
        end
        last[i] = t;
      end
      tick();
    end
    while (gseq.size() < 5) gseq.push_back(-1);
    for (int k = 0; k < 5; k++) begin
      checks++; if (gseq[k] != k % N) begin errors++; $display("FAIL rotate_grant%0d got=%0d exp=%0d", k, gseq[k], k % N); end
    end
    m_req = '0; s_res = '0;
  endtask

  task automatic test_read_data();
    do_reset();
    m_req[1] = mk(1, 0, 32'h100, 0);
    #1;
    checks++; if (busy !== 1'b0 || s_req !== '0 || m_res !== '0) begin
      errors++; $display("FAIL read_idle busy=%0b sreq=%h mres=%h exp=0", busy, s_req, m_res);
    end
    tick();
    s_res = '{ready: 1'b1, error: 1'b0, rdata: 32'hDEADBEEF};
    #1;
    checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL read_grant got=%0d exp=1", grant_id); end
    checks++; if (s_req !== m_req[1] || s_req.addr !== 32'h100) begin errors++; $display("FAIL read_sreq got=%h exp=%h", s_req, m_req[1]); end
    checks++; if (m_res[1] !== 34'h2DEADBEEF) begin errors++; $display("FAIL read_mres1 got=%h exp=2deadbeef", m_res[1]); end
    checks++; if (m_res[0] !== '0 || m_res[2] !== '0 || m_res[3] !== '0) begin
      errors++; $display("FAIL read_others got=%h exp=0 except m1", m_res);
    end
    tick();
    m_req = '0; s_res = '0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_done got=%0b exp=0", busy); end
    tick();
  endtask

  task automatic test_timeout(input logic late_ready);
    do_reset();
    m_req[3] = mk(0, 1, 32'h300, 32'hA5);
    #1; tick();
    for (int b = 1; b <= TO; b++) begin
      if (b == TO && late_ready) s_res = '{ready: 1'b1, error: 1'b0, rdata: 32'h12345678};
      #1;
      if (b < TO) begin
        checks++; if (busy !== 1'b1 || m_res[3].ready !== 1'b0) begin
          errors++; $display("FAIL to_wait b=%0d busy=%0b ready=%0b exp busy=1 ready=0", b, busy, m_res[3].ready);
        end
      end else if (late_ready) begin
        checks++; if (m_res[3] !== 34'h212345678) begin errors++; $display("FAIL to_ready_mres got=%h exp=212345678", m_res[3]); end
        checks++; if (s_req !== m_req[3]) begin errors++; $display("FAIL to_ready_sreq got=%h exp=%h", s_req, m_req[3]); end
      end else begin
        checks++; if (m_res[3] !== 34'h300000000) begin errors++; $display("FAIL to_err_mres got=%h exp=300000000", m_res[3]); end
        checks++; if (s_req !== '0) begin errors++; $display("FAIL to_err_sreq got=%h exp=0", s_req); end
      end
      tick();
    end
    m_req = '0; s_res = '0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle got=%0b exp=0", busy); end
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    m_req[2] = mk(1, 0, 32'h200, 0);
    #1; tick();
    #1;
    checks++; if (busy !== 1'b1 || grant_id !== 2'd2) begin errors++; $display("FAIL arst_pre busy=%0b grant=%0d exp 1,2", busy, grant_id); end
    #2 nrst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || s_req !== '0 || m_res !== '0) begin
      errors++; $display("FAIL arst_async busy=%0b sreq=%h mres=%h exp=0", busy, s_req, m_res);
    end
    model_reset();
    @(negedge clk);
    nrst = 1'b1;
    m_req[0] = mk(1, 0, 32'h0, 0);
    #1; tick();
    #1;
    checks++; if (busy !== 1'b1 || grant_id !== 2'd0) begin errors++; $display("FAIL arst_regrant busy=%0b grant=%0d exp 1,0", busy, grant_id); end
    tick();
    m_req = '0;
  endtask

  task automatic test_drop();
    do_reset();
    m_req[1] = mk(1, 0, 32'h40, 0);
    #1; tick();
    #1;
    checks++; if (busy !== 1'b1 || grant_id !== 2'd1) begin errors++; $display("FAIL drop_grant busy=%0b grant=%0d exp 1,1", busy, grant_id); end
    tick();
    m_req[1] = '0; m_req[0] = mk(1, 0, 32'h0, 0); m_req[2] = mk(1, 0, 32'h80, 0);
    #1;
    checks++; if (m_res !== '0) begin errors++; $display("FAIL drop_nores got=%h exp=0", m_res); end
    tick();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle got=%0b exp=0", busy); end
    tick();
    #1;
    checks++; if (busy !== 1'b1 || grant_id !== 2'd2) begin errors++; $display("FAIL drop_next busy=%0b grant=%0d exp 1,2", busy, grant_id); end
    tick();
    m_req = '0;
  endtask

  task automatic test_single();
    do_reset();
    m_req[2] = mk(1, 0, 32'h8, 0);
    #1; tick();
    s_res = '{ready: 1'b1, error: 1'b0, rdata: 32'h5};
    #1;
    checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_first got=%0d exp=2", grant_id); end
    tick();
    m_req = '0; s_res = '0;
    #1; tick();
    m_req[2] = mk(0, 1, 32'h8, 32'h9);
    #1; tick();
    #1;
    checks++; if (busy !== 1'b1 || grant_id !== 2'd2) begin errors++; $display("FAIL single_again busy=%0b grant=%0d exp 1,2", busy, grant_id); end
    tick();
    m_req = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] done;
    logic [1:0] r;
    do_reset();
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) if (!(m_req[i].ren || m_req[i].wen) && $urandom_range(0, 2) == 0) begin
        r = 2'($urandom_range(1, 3));
        m_req[i] = mk(r[0], r[1], $urandom, $urandom);
      end
      s_res = '{ready: $urandom_range(0, 3) == 0, error: $urandom_range(0, 7) == 0, rdata: $urandom};
      #1;
      checks++; if (busy !== (md_busy != 0)) begin errors++; $display("FAIL rnd_busy t=%0d got=%0b exp=%0d", t, busy, md_busy); end
      checks++; if (busy && grant_id !== 2'(md_grant)) begin errors++; $display("FAIL rnd_grant t=%0d got=%0d exp=%0d", t, grant_id, md_grant); end
      checks++; if (s_req !== e_sreq) begin errors++; $display("FAIL rnd_sreq t=%0d got=%h exp=%h", t, s_req, e_sreq); end
      checks++; if (m_res !== e_mres) begin errors++; $display("FAIL rnd_mres t=%0d got=%h exp=%h", t, m_res, e_mres); end
      for (int i = 0; i < N; i++) done[i] = e_mres[i].ready;
      tick();
      for (int i = 0; i < N; i++) if (done[i]) m_req[i] = '0;
    end
    m_req = '0; s_res = '0;
  endtask

  initial begin
    m_req = '0; s_res = '0; model_reset();
    test_reset();
    test_pair();
    test_rotate();
    test_read_data();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_async_reset();
    test_drop();
    test_single();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
